// File: rtl/comparator_seq_ctrl.sv
// Multi-cycle magnitude comparator: MSB-first scan, one 2-bit slice per cycle.
// Optional macro COMPARATOR_SEQ_EARLY_EXIT_EN ends the scan at the first differing pair.
module comparator_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NP = WIDTH / 2;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sa, sb;
  logic [1:0]       pa, pb;
  logic             pgt, plt;
  logic             last, fin, accept;

`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
  logic dec, dgt;
`endif

  // Shadows shift left each cycle, so the active pair is always the top two bits.
  assign pa = sa[WIDTH-1 -: 2];
  assign pb = sb[WIDTH-1 -: 2];

  assign pgt = (pa[1] & ~pb[1]) | (~(pa[1] ^ pb[1]) & pa[0] & ~pb[0]);
  assign plt = (~pa[1] & pb[1]) | (~(pa[1] ^ pb[1]) & ~pa[0] & pb[0]);

  assign last   = (idx == '0);
  assign accept = (state == IDLE) && start;
  assign busy   = (state == SCAN);

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  assign fin = last | pgt | plt;
`else
  assign fin = last;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: start only matters in IDLE, scan ends on fin.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = SCAN;
      SCAN: if (fin)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, pair stepping and result latching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      idx  <= '0;
      done <= 1'b0;
      gt   <= 1'b0;
      eq   <= 1'b0;
      lt   <= 1'b0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
      dec  <= 1'b0;
      dgt  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        idx <= IW'(NP - 1);
        gt  <= 1'b0;
        eq  <= 1'b0;
        lt  <= 1'b0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
        dec <= 1'b0;
        dgt <= 1'b0;
`endif
      end else if (state == SCAN) begin
        sa  <= sa << 2;
        sb  <= sb << 2;
        idx <= idx - 1'b1;
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
        if (fin) begin
          done <= 1'b1;
          gt   <= pgt;
          lt   <= plt;
          eq   <= ~(pgt | plt);
        end
`else
        // The first differing pair decides; later pairs cannot override it.
        if (!dec && (pgt || plt)) begin
          dec <= 1'b1;
          dgt <= pgt;
        end
        if (fin) begin
          done <= 1'b1;
          gt   <= dec ? dgt  : pgt;
          lt   <= dec ? ~dgt : plt;
          eq   <= ~dec & ~(pgt | plt);
        end
`endif
      end
    end
  end

endmodule
